clk_enable_gen: RTL and testbench



---
 rtl/clk_enable_gen.sv | 105 ++++++++++
 tb/tb_clk_enable_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel divisors with turbo scaling,
// pause/single-step debug control, phase resync and a channel-0 enable counter.
module clk_enable_gen #(
  parameter int unsigned           NUM_CHANNELS = 2,
  parameter int unsigned           DIV_WIDTH    = 12,
  parameter logic [DIV_WIDTH-1:0]  DEFAULT_DIV  = 12'hBF4,
  parameter int unsigned           COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    div_wr,
  input  logic [2:0]              div_wr_ch,
  input  logic [DIV_WIDTH-1:0]    div_wr_value,
  input  logic [1:0]              turbo,
  input  logic                    pause,
  input  logic                    step_req,
  input  logic                    resync,
  output logic [NUM_CHANNELS-1:0] clk_en,
  output logic                    step_done,
  output logic                    halted,
  output logic [COUNT_WIDTH-1:0]  en_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_STEP
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0]   div_nx [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0]   cnt_q  [NUM_CHANNELS];
  logic                   running;
  logic                   step_done_q;
  logic [COUNT_WIDTH-1:0] en_count_q;

  // Reload value E-1 with E = max(d >> t, 1); a zero period collapses to 1.
  function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [DIV_WIDTH-1:0] d,
                                                     input logic [1:0]           t);
    logic [DIV_WIDTH-1:0] e;
    e = d >> t;
    if (e == '0) return '0;
    return e - 1'b1;
  endfunction

  assign running = (state_q != ST_HALT);

  always_comb begin
    clk_en = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      div_nx[i] = (div_wr && (div_wr_ch == 3'(i))) ? div_wr_value : div_q[i];
      clk_en[i] = running && (cnt_q[i] == '0) && !resync;
    end
  end

  // A plain reload uses the registered divisor so a write never alters the
  // period in flight; only resync picks up a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        div_q[i] <= DEFAULT_DIV;
        cnt_q[i] <= DEFAULT_DIV - 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        div_q[i] <= div_nx[i];
        if (resync)
          cnt_q[i] <= reload_of(div_nx[i], turbo);
        else if (running)
          cnt_q[i] <= (cnt_q[i] == '0) ? reload_of(div_q[i], turbo) : cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (pause) state_d = ST_HALT;
      ST_HALT: begin
        if (!pause)        state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_STEP: if (clk_en[0]) state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      step_done_q <= 1'b0;
      en_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_done_q <= (state_q == ST_STEP) && clk_en[0];
      en_count_q  <= en_count_q + COUNT_WIDTH'(clk_en[0]);
    end
  end

  assign step_done = step_done_q;
  assign halted    = (state_q == ST_HALT);
  assign en_count  = en_count_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomised and directed bench for clk_enable_gen against a cycle-countdown reference model.
module tb_clk_enable_gen;
  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int DEF = 5;
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           div_wr = 1'b0;
  logic [2:0]     div_wr_ch = '0;
  logic [DW-1:0]  div_wr_value = '0;
  logic [1:0]     turbo = '0;
  logic           pause = 1'b0;
  logic           step_req = 1'b0;
  logic           resync = 1'b0;
  logic [NCH-1:0] clk_en;
  logic           step_done;
  logic           halted;
  logic [31:0]    en_count;

  clk_enable_gen #(
    .NUM_CHANNELS (NCH),
    .DIV_WIDTH    (DW),
    .DEFAULT_DIV  (12'd5),
    .COUNT_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div_wr       (div_wr),
    .div_wr_ch    (div_wr_ch),
    .div_wr_value (div_wr_value),
    .turbo        (turbo),
    .pause        (pause),
    .step_req     (step_req),
    .resync       (resync),
    .clk_en       (clk_en),
    .step_done    (step_done),
    .halted       (halted),
    .en_count     (en_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: cycles remaining until each channel's next enable.
  int          m_div [NCH];
  int          m_rem [NCH];
  int          m_mode;
  bit          m_sd;
  int unsigned m_cnt;
  logic [NCH-1:0] obs_en;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int d, input int t);
    int e;
    e = d >> t;
    return (e < 1) ? 1 : e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEF;
      m_rem[i] = DEF - 1;
    end
    m_mode = M_RUN;
    m_sd   = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    div_wr = 1'b0; pause = 1'b0; step_req = 1'b0; resync = 1'b0; turbo = '0;
    #1;
    check_val("rst_clk_en", clk_en, '0);
    check_val("rst_halted", halted, 0);
    check_val("rst_step_done", step_done, 0);
    check_val("rst_en_count", en_count, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic tick(input bit wr, input int ch, input int val, input int t,
                      input bit p, input bit sr, input bit rs);
    logic [NCH-1:0] exp_en;
    int nd;
    @(negedge clk);
    div_wr = wr; div_wr_ch = 3'(ch); div_wr_value = DW'(val);
    turbo = 2'(t); pause = p; step_req = sr; resync = rs;
    #1;
    for (int i = 0; i < NCH; i++)
      exp_en[i] = (m_mode != M_HALT) && (m_rem[i] == 0) && !rs;
    check_val("clk_en", clk_en, exp_en);
    check_val("halted", halted, (m_mode == M_HALT));
    check_val("step_done", step_done, m_sd);
    check_val("en_count", en_count, m_cnt);
    obs_en = clk_en;
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      nd = (wr && ch == i) ? (val & 12'hFFF) : m_div[i];
      if (rs)
        m_rem[i] = eff(nd, t) - 1;
      else if (m_mode != M_HALT)
        m_rem[i] = (m_rem[i] == 0) ? eff(m_div[i], t) - 1 : m_rem[i] - 1;
      m_div[i] = nd;
    end
    m_sd  = (m_mode == M_STEP) && exp_en[0];
    m_cnt = m_cnt + exp_en[0];
    case (m_mode)
      M_RUN:   if (p) m_mode = M_HALT;
      M_HALT:  if (!p) m_mode = M_RUN; else if (sr) m_mode = M_STEP;
      default: if (exp_en[0]) m_mode = M_HALT;
    endcase
  endtask

  task automatic idle(input int n, input int t);
    for (int k = 0; k < n; k++) tick(0, 0, 0, t, 0, 0, 0);
  endtask

  initial begin
    int pulses[$];
    bit p_lvl;
    int t_cur;

    // First pulses after reset at cycles 4, 9, 14.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      if (obs_en[0]) pulses.push_back(k);
    end
    #1;
    check_val("first_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check_val("first_pulse_0", pulses[0], 4);
      check_val("first_pulse_1", pulses[1], 9);
      check_val("first_pulse_2", pulses[2], 14);
    end
    check_val("en_count_after_14", en_count, 3);

    // Divisor write mid-period on channel 1.
    do_reset();
    idle(2, 0);
    tick(1, 1, 3, 0, 0, 0, 0);
    idle(15, 0);

    // Turbo change mid-period, then period collapsed to 1.
    tick(1, 0, 12, 0, 0, 0, 1);
    idle(4, 0);
    idle(20, 2);
    tick(1, 0, 2, 3, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 0, 3, 0, 0, 0);
      check_val("turbo_continuous", obs_en[0], 1);
    end

    // Pause, hold, single step.
    do_reset();
    idle(2, 0);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 0, 0, 1, 0, 0);
      if (k > 0) check_val("paused_no_en", obs_en, '0);
    end
    tick(0, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) tick(0, 0, 0, 0, 1, 0, 0);
    idle(6, 0);

    // Resync aligns both channels after a divergent write.
    tick(1, 1, 7, 0, 0, 0, 0);
    idle(3, 0);
    tick(1, 1, 5, 0, 0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      check_val("resync_aligned", obs_en[1], obs_en[0]);
    end

    // Reset asserted while a step is in flight.
    do_reset();
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    do_reset();
    idle(12, 0);

    // Randomised traffic.
    p_lvl = 0;
    t_cur = 0;
    for (int k = 0; k < 3000; k++) begin
      bit wr, sr, rs;
      if ($urandom_range(0, 39) == 0) p_lvl = !p_lvl;
      if ($urandom_range(0, 59) == 0) t_cur = $urandom_range(0, 3);
      wr = ($urandom_range(0, 29) == 0);
      sr = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 49) == 0);
      tick(wr, $urandom_range(0, 7), $urandom_range(0, 20), t_cur, p_lvl, sr, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
